fp16_accum_seq: RTL and testbench

//  Sequential accumulation stage around the combinational FP16 adder (FloatingAdderHF).

---
 rtl/fp16_pkg.sv | 33 +++
 rtl/fp16_exp_sat_chk.sv | 15 +
 rtl/fp16_accum_seq.sv | 157 +++++++++++++++
 tb/tb_fp16_accum_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the accumulation stage: constants, field
// positions, the controller state encoding and a small field helper.
package fp16_pkg;

   localparam logic [15:0] FP16_ZERO    = 16'h0000;
   localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

   localparam int FP16_SIGN_BIT = 15;
   localparam int FP16_EXP_MSB  = 14;
   localparam int FP16_EXP_LSB  = 10;
   localparam int FP16_MAN_MSB  = 9;
   localparam int FP16_MAN_LSB  = 0;

   // IDLE: no packet open, ACC: packet open, DONE: result held for consumer
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } acc_state_t;

   function automatic logic fp16_sign(input logic [15:0] v);
      return v[FP16_SIGN_BIT];
   endfunction

   function automatic logic [4:0] fp16_exp(input logic [15:0] v);
      return v[FP16_EXP_MSB:FP16_EXP_LSB];
   endfunction

   function automatic logic [9:0] fp16_man(input logic [15:0] v);
      return v[FP16_MAN_MSB:FP16_MAN_LSB];
   endfunction

endpackage

// File: rtl/fp16_exp_sat_chk.sv
// Flags an FP16 value whose exponent field is all ones (infinity or NaN),
// which the accumulator treats as an overflowed intermediate sum.
module fp16_exp_sat_chk
   import fp16_pkg::*;
(
   input  logic [15:0] val,
   output logic        is_max
);

   // Pure compare on the exponent field
   always_comb begin
      is_max = (fp16_exp(val) == FP16_EXP_MAX);
   end

endmodule

// File: rtl/fp16_accum_seq.sv
// Sequential packet accumulator wrapped around an external combinational
// FP16 adder. Each accepted beat folds one operand into the running sum;
// the last beat of a packet moves sum, element count and overflow flag into
// a held output register with a valid/ready handshake.
module fp16_accum_seq
   import fp16_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   input  logic             in_op,
   input  logic             in_last,
   output logic [15:0]      add_a,
   output logic [15:0]      add_b,
   output logic             add_op,
   input  logic [15:0]      add_res,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
   output logic [CNT_W-1:0] out_cnt,
   output logic             out_ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   acc_state_t       state_q, state_d;
   logic [15:0]      acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;
   logic [15:0]      out_data_q, out_data_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic             out_ovf_q, out_ovf_d;

   logic             res_exp_max;
   logic             beat_accept;
   logic [CNT_W-1:0] cnt_base;
   logic [CNT_W-1:0] cnt_next;
   logic             ovf_next;

   fp16_exp_sat_chk u_res_chk (
      .val    (add_res),
      .is_max (res_exp_max)
   );

   // Adder hookup and input handshake; a fresh packet starts from +0 so the
   // first beat yields +x or -x depending on the op
   always_comb begin
      in_ready    = (state_q != ST_DONE) && !clr;
      beat_accept = in_valid && in_ready;
      add_a       = (state_q == ST_IDLE) ? FP16_ZERO : acc_q;
      add_b       = in_data;
      add_op      = in_op;
   end

   // Count and overflow candidates for the current beat; in IDLE the stale
   // packet state is ignored so a new packet always starts at one element
   always_comb begin
      cnt_base = (state_q == ST_IDLE) ? '0 : cnt_q;
      cnt_next = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + CNT_ONE;
      ovf_next = ((state_q == ST_IDLE) ? 1'b0 : ovf_q) | res_exp_max;
   end

   // Controller: next state plus all register updates; clr wins over
   // both the input beat and the output handshake
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_cnt_d   = out_cnt_q;
      out_ovf_d   = out_ovf_q;

      if (clr) begin
         state_d     = ST_IDLE;
         acc_d       = FP16_ZERO;
         cnt_d       = '0;
         ovf_d       = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_ACC: begin
               if (beat_accept) begin
                  if (in_last) begin
                     out_data_d  = add_res;
                     out_cnt_d   = cnt_next;
                     out_ovf_d   = ovf_next;
                     out_valid_d = 1'b1;
                     state_d     = ST_DONE;
                  end else begin
                     acc_d   = add_res;
                     cnt_d   = cnt_next;
                     ovf_d   = ovf_next;
                     state_d = ST_ACC;
                  end
               end
            end
            ST_DONE: begin
               if (out_valid_q && out_ready) begin
                  out_valid_d = 1'b0;
                  acc_d       = FP16_ZERO;
                  cnt_d       = '0;
                  ovf_d       = 1'b0;
                  state_d     = ST_IDLE;
               end
            end
            default: begin
               state_d     = ST_IDLE;
               acc_d       = FP16_ZERO;
               cnt_d       = '0;
               ovf_d       = 1'b0;
               out_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= FP16_ZERO;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= FP16_ZERO;
         out_cnt_q   <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_cnt_q   <= out_cnt_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   // Registered outputs
   always_comb begin
      out_valid = out_valid_q;
      out_data  = out_data_q;
      out_cnt   = out_cnt_q;
      out_ovf   = out_ovf_q;
   end

endmodule

// File: tb/tb_fp16_accum_seq.sv
// Bench for fp16_accum_seq: two instances (CNT_W=8 and CNT_W=2) share one
// input stream; a behavioural FP16 adder built on real arithmetic stands in
// for FloatingAdderHF, and a packet-level model predicts every result.
module tb_fp16_accum_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_op;
   logic        in_last;
   logic        out_ready;

   logic        in_ready8, add_op8, out_valid8, out_ovf8;
   logic [15:0] add_a8, add_b8, add_res8, out_data8;
   logic [7:0]  out_cnt8;

   logic        in_ready2, add_op2, out_valid2, out_ovf2;
   logic [15:0] add_a2, add_b2, add_res2, out_data2;
   logic [1:0]  out_cnt2;

   int n_checks = 0;
   int n_fail   = 0;

   // Packet model state
   logic        m_open;
   logic [15:0] m_acc;
   int          m_cnt;
   logic        m_ovf;
   logic [15:0] m_res;
   int          m_res_cnt;
   logic        m_res_ovf;

   always #5 clk = ~clk;

   // ---------------- behavioural FP16 arithmetic ----------------
   function automatic real pow2(input int e);
      real p = 1.0;
      if (e >= 0) for (int i = 0; i < e; i++) p = p * 2.0;
      else        for (int i = 0; i < -e; i++) p = p / 2.0;
      return p;
   endfunction

   function automatic int roundEven(input real m);
      real fl = $floor(m);
      real fr = m - fl;
      int  i  = int'(fl);
      if (fr > 0.5 || (fr == 0.5 && i[0])) i = i + 1;
      return i;
   endfunction

   function automatic real halfToReal(input logic [15:0] h);
      int  e = int'(h[14:10]);
      int  m = int'(h[9:0]);
      real v;
      if (e == 31)     v = 1.0e9;
      else if (e == 0) v = real'(m) * pow2(-24);
      else             v = real'(1024 + m) * pow2(e - 25);
      return h[15] ? -v : v;
   endfunction

   function automatic logic [15:0] realToHalf(input real r);
      logic s = (r < 0.0);
      real  a = s ? -r : r;
      int   e;
      int   mi;
      logic [15:0] mv;
      if (a == 0.0) return 16'h0000;
      if (a >= 65520.0) return {s, 5'h1F, 10'h000};
      if (a < pow2(-14)) begin
         mi = roundEven(a * pow2(24));
         mv = 16'(mi);
         return {s, mv[14:0]};
      end
      e = -14;
      while (a >= pow2(e + 1)) e++;
      mi = roundEven(a * pow2(10 - e));
      if (mi == 2048) begin
         e  = e + 1;
         mi = 1024;
      end
      if (e > 15) return {s, 5'h1F, 10'h000};
      return {s, 5'(e + 15), 10'(mi - 1024)};
   endfunction

   function automatic logic [15:0] fp16Add(input logic [15:0] a, input logic [15:0] b,
                                           input logic op);
      real rb = halfToReal(b);
      return realToHalf(halfToReal(a) + (op ? -rb : rb));
   endfunction

   // Adder stand-ins, combinational from each instance's add_* outputs
   always_comb add_res8 = fp16Add(add_a8, add_b8, add_op8);
   always_comb add_res2 = fp16Add(add_a2, add_b2, add_op2);

   fp16_accum_seq #(.CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
      .in_op(in_op), .in_last(in_last),
      .add_a(add_a8), .add_b(add_b8), .add_op(add_op8), .add_res(add_res8),
      .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
      .out_cnt(out_cnt8), .out_ovf(out_ovf8)
   );

   fp16_accum_seq #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
      .in_op(in_op), .in_last(in_last),
      .add_a(add_a2), .add_b(add_b2), .add_op(add_op2), .add_res(add_res2),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
      .out_cnt(out_cnt2), .out_ovf(out_ovf2)
   );

   // ---------------- checking ----------------
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      m_open = 1'b0;
      m_acc  = 16'h0000;
      m_cnt  = 0;
      m_ovf  = 1'b0;
   endtask

   // Packet-level model: running sum starts at +0, count and overflow are
   // per packet, the last beat publishes the result
   task automatic modelBeat(input logic [15:0] d, input logic op, input logic last);
      logic [15:0] s = fp16Add(m_open ? m_acc : 16'h0000, d, op);
      int          c = (m_open ? m_cnt : 0) + 1;
      logic        o = (m_open ? m_ovf : 1'b0) | (s[14:10] == 5'h1F);
      if (last) begin
         m_res     = s;
         m_res_cnt = c;
         m_res_ovf = o;
         modelReset();
      end else begin
         m_open = 1'b1;
         m_acc  = s;
         m_cnt  = c;
         m_ovf  = o;
      end
   endtask

   // Drive one beat and hold it until accepted (bounded); entered and left
   // just after a rising edge
   task automatic applyStimulus(input logic [15:0] d, input logic op, input logic last);
      logic accepted = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_op    = op;
      in_last  = last;
      for (int i = 0; i < 20 && !accepted; i++) begin
         @(negedge clk);
         if (in_ready8) begin
            @(posedge clk);
            #1;
            accepted = 1'b1;
         end
      end
      in_valid = 1'b0;
      if (accepted) modelBeat(d, op, last);
      else checkOutput("accept_timeout", 32'(accepted), 32'd1);
   endtask

   function automatic int sat(input int c, input int mx);
      return (c > mx) ? mx : c;
   endfunction

   // Check the held result against the model, stall the consumer, then
   // complete the handshake and confirm the block is ready again
   task automatic collectResult(input string tag, input int stall);
      for (int i = 0; i <= stall; i++) begin
         checkOutput({tag, "_valid"}, 32'(out_valid8), 32'd1);
         checkOutput({tag, "_data"},  32'(out_data8),  32'(m_res));
         checkOutput({tag, "_cnt8"},  32'(out_cnt8),   32'(sat(m_res_cnt, 255)));
         checkOutput({tag, "_cnt2"},  32'(out_cnt2),   32'(sat(m_res_cnt, 3)));
         checkOutput({tag, "_data2"}, 32'(out_data2),  32'(m_res));
         checkOutput({tag, "_ovf"},   32'(out_ovf8),   32'(m_res_ovf));
         checkOutput({tag, "_inrdy"}, 32'(in_ready8),  32'd0);
         if (i < stall) begin
            @(posedge clk);
            #1;
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, "_drop"},  32'(out_valid8), 32'd0);
      checkOutput({tag, "_ready"}, 32'(in_ready8),  32'd1);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      rst       = 1'b1;
      clr       = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      in_op     = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      modelReset();
      m_res     = 16'h0000;
      m_res_cnt = 0;
      m_res_ovf = 1'b0;

      #1;
      checkOutput("rst_valid", 32'(out_valid8), 32'd0);
      checkOutput("rst_data",  32'(out_data8),  32'd0);
      checkOutput("rst_cnt",   32'(out_cnt8),   32'd0);
      checkOutput("rst_ovf",   32'(out_ovf8),   32'd0);
      checkOutput("rst_ready", 32'(in_ready8),  32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] basic packets");
      applyStimulus(16'h3C00, 1'b0, 1'b0);
      applyStimulus(16'h4000, 1'b0, 1'b1);
      checkOutput("p1_const", 32'(out_data8), 32'h4200);
      collectResult("p1", 0);

      applyStimulus(16'h4200, 1'b0, 1'b0);
      applyStimulus(16'h3C00, 1'b1, 1'b1);
      checkOutput("p2_const", 32'(out_data8), 32'h4000);
      collectResult("p2", 0);

      applyStimulus(16'h3800, 1'b1, 1'b1);
      checkOutput("p3_const", 32'(out_data8), 32'hB800);
      checkOutput("p3_cnt",   32'(out_cnt8),  32'd1);
      collectResult("p3", 0);

      $display("[TB] overflow packet");
      applyStimulus(16'h7BFF, 1'b0, 1'b0);
      applyStimulus(16'h7BFF, 1'b0, 1'b1);
      checkOutput("ovf_flag", 32'(out_ovf8),          32'd1);
      checkOutput("ovf_exp",  32'(out_data8[14:10]),  32'h1F);
      checkOutput("ovf_cnt",  32'(out_cnt8),          32'd2);
      collectResult("ovf", 0);

      $display("[TB] consumer stall with pending beat");
      applyStimulus(16'h3C00, 1'b0, 1'b0);
      applyStimulus(16'h3C00, 1'b0, 1'b1);
      in_valid = 1'b1;
      in_data  = 16'h4400;
      in_op    = 1'b0;
      in_last  = 1'b1;
      collectResult("stall", 5);
      in_valid = 1'b0;

      $display("[TB] synchronous clear mid-packet");
      applyStimulus(16'h4000, 1'b0, 1'b0);
      applyStimulus(16'h4000, 1'b0, 1'b0);
      clr      = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'h4000;
      in_last  = 1'b0;
      @(negedge clk);
      checkOutput("clr_inrdy", 32'(in_ready8), 32'd0);
      @(posedge clk);
      #1;
      clr      = 1'b0;
      in_valid = 1'b0;
      modelReset();
      checkOutput("clr_valid", 32'(out_valid8), 32'd0);
      checkOutput("clr_adda",  32'(add_a8),     32'd0);
      applyStimulus(16'h3C00, 1'b0, 1'b1);
      checkOutput("clr_next",  32'(out_data8), 32'h3C00);
      checkOutput("clr_cnt",   32'(out_cnt8),  32'd1);
      collectResult("clrpkt", 0);

      $display("[TB] asynchronous reset mid-packet");
      applyStimulus(16'h3C00, 1'b0, 1'b0);
      applyStimulus(16'h3C00, 1'b0, 1'b0);
      checkOutput("prerst_adda", 32'(add_a8), 32'h4000);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_valid", 32'(out_valid8), 32'd0);
      checkOutput("arst_data",  32'(out_data8),  32'd0);
      checkOutput("arst_cnt",   32'(out_cnt8),   32'd0);
      checkOutput("arst_adda",  32'(add_a8),     32'd0);
      @(negedge clk);
      rst = 1'b0;
      modelReset();
      @(posedge clk);
      #1;

      $display("[TB] counter saturation");
      for (int i = 0; i < 5; i++) applyStimulus(16'h3C00, 1'b0, (i == 4));
      checkOutput("sat_data", 32'(out_data8), 32'h4500);
      checkOutput("sat_cnt2", 32'(out_cnt2),  32'd3);
      checkOutput("sat_cnt8", 32'(out_cnt8),  32'd5);
      collectResult("sat", 1);

      for (int i = 0; i < 260; i++) applyStimulus(16'h3C00, i[0], (i == 259));
      checkOutput("long_cnt8", 32'(out_cnt8), 32'd255);
      collectResult("long", 0);

      $display("[TB] random packets");
      for (int p = 0; p < 25; p++) begin
         int len = $urandom_range(1, 6);
         for (int b = 0; b < len; b++) begin
            logic [15:0] d;
            d[15]    = 1'($urandom_range(0, 1));
            d[14:10] = 5'($urandom_range(12, 18));
            d[9:0]   = 10'($urandom);
            idleCycles($urandom_range(0, 2));
            applyStimulus(d, 1'($urandom_range(0, 1)), (b == len - 1));
         end
         collectResult("rnd", $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
